// File: rtl/block_device_initiator.sv
// Initiator for the block-device req/data/resp protocol: one sector-granular command at a time.
// Optional BLKDEV_BOUNDS_CHECK_EN rejects commands whose offset+len exceeds bdev_info_nsectors.
module block_device_initiator #(
   parameter int ADDR_BITS   = 32,
   parameter int SECTOR_BITS = 32,
   parameter int DATA_BITS   = 64,
   parameter int TAG_BITS    = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [ADDR_BITS-1:0]   cmd_addr,
   input  logic [SECTOR_BITS-1:0] cmd_offset,
   input  logic [SECTOR_BITS-1:0] cmd_len,
   input  logic [TAG_BITS-1:0]    cmd_tag,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [DATA_BITS-1:0]   wr_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [DATA_BITS-1:0]   rd_data,
   output logic                   rd_last,
   output logic                   done_valid,
   input  logic                   done_ready,
   output logic [TAG_BITS-1:0]    done_tag,
   output logic                   done_err,
   output logic                   bdev_req_valid,
   input  logic                   bdev_req_ready,
   output logic                   bdev_req_bits_write,
   output logic [ADDR_BITS-1:0]   bdev_req_bits_addr,
   output logic [SECTOR_BITS-1:0] bdev_req_bits_offset,
   output logic [SECTOR_BITS-1:0] bdev_req_bits_len,
   output logic [TAG_BITS-1:0]    bdev_req_bits_tag,
   output logic                   bdev_data_valid,
   input  logic                   bdev_data_ready,
   output logic [DATA_BITS-1:0]   bdev_data_bits_data,
   output logic [TAG_BITS-1:0]    bdev_data_bits_tag,
   input  logic                   bdev_resp_valid,
   output logic                   bdev_resp_ready,
   input  logic [DATA_BITS-1:0]   bdev_resp_bits_data,
   input  logic [TAG_BITS-1:0]    bdev_resp_bits_tag,
   input  logic [SECTOR_BITS-1:0] bdev_info_nsectors
);

   localparam int BEAT_BITS = SECTOR_BITS + 6;
   localparam int BEATS_PER_SECTOR = 4096 / DATA_BITS;
   localparam logic [BEAT_BITS-1:0] ONE_BEAT = BEAT_BITS'(1);

   typedef enum logic [2:0] {IDLE, REQ, WDATA, WRESP, RDATA, DONE} state_t;

   state_t                 state_q, state_d;
   logic                   write_q, write_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [SECTOR_BITS-1:0] offset_q, offset_d;
   logic [SECTOR_BITS-1:0] len_q, len_d;
   logic [TAG_BITS-1:0]    tag_q, tag_d;
   logic [BEAT_BITS-1:0]   beats_q, beats_d;
   logic                   err_q, err_d;
   logic                   armed_q;
   logic                   outOfRange;
   logic                   tagBad;

   `ifdef BLKDEV_BOUNDS_CHECK_EN
   // One extra bit so a wrapping offset+len is still seen as out of range
   logic [SECTOR_BITS:0] endSector;
   assign endSector  = {1'b0, cmd_offset} + {1'b0, cmd_len};
   assign outOfRange = endSector > {1'b0, bdev_info_nsectors};
   `else
   logic unused_nsectors;
   assign unused_nsectors = ^bdev_info_nsectors;
   assign outOfRange = 1'b0;
   `endif

   assign tagBad = bdev_resp_bits_tag != tag_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         addr_q   <= '0;
         offset_q <= '0;
         len_q    <= '0;
         tag_q    <= '0;
         beats_q  <= '0;
         err_q    <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         offset_q <= offset_d;
         len_q    <= len_d;
         tag_q    <= tag_d;
         beats_q  <= beats_d;
         err_q    <= err_d;
         armed_q  <= 1'b1;
      end
   end

   // armed_q keeps cmd_ready low while reset is asserted, even though state is IDLE
   always_comb begin
      state_d             = state_q;
      write_d             = write_q;
      addr_d              = addr_q;
      offset_d            = offset_q;
      len_d               = len_q;
      tag_d               = tag_q;
      beats_d             = beats_q;
      err_d               = err_q;
      cmd_ready           = 1'b0;
      bdev_req_valid      = 1'b0;
      bdev_data_valid     = 1'b0;
      bdev_data_bits_data = '0;
      wr_ready            = 1'b0;
      bdev_resp_ready     = 1'b0;
      rd_valid            = 1'b0;
      rd_data             = '0;
      rd_last             = 1'b0;
      done_valid          = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = armed_q;
            if (cmd_valid && armed_q) begin
               write_d  = cmd_write;
               addr_d   = cmd_addr;
               offset_d = cmd_offset;
               len_d    = cmd_len;
               tag_d    = cmd_tag;
               err_d    = outOfRange;
               beats_d  = BEAT_BITS'(cmd_len) * BEAT_BITS'(BEATS_PER_SECTOR);
               state_d  = (outOfRange || cmd_len == '0) ? DONE : REQ;
            end
         end
         REQ: begin
            bdev_req_valid = 1'b1;
            if (bdev_req_ready) state_d = write_q ? WDATA : RDATA;
         end
         WDATA: begin
            bdev_data_valid     = wr_valid;
            wr_ready            = bdev_data_ready;
            bdev_data_bits_data = wr_data;
            if (wr_valid && bdev_data_ready) begin
               beats_d = beats_q - ONE_BEAT;
               if (beats_q == ONE_BEAT) state_d = WRESP;
            end
         end
         WRESP: begin
            bdev_resp_ready = 1'b1;
            if (bdev_resp_valid) begin
               if (tagBad) err_d = 1'b1;
               state_d = DONE;
            end
         end
         RDATA: begin
            rd_valid        = bdev_resp_valid;
            bdev_resp_ready = rd_ready;
            rd_data         = bdev_resp_bits_data;
            rd_last         = beats_q == ONE_BEAT;
            if (bdev_resp_valid && rd_ready) begin
               if (tagBad) err_d = 1'b1;
               beats_d = beats_q - ONE_BEAT;
               if (beats_q == ONE_BEAT) state_d = DONE;
            end
         end
         DONE: begin
            done_valid = 1'b1;
            if (done_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign done_tag             = tag_q;
   assign done_err             = err_q;
   assign bdev_req_bits_write  = write_q;
   assign bdev_req_bits_addr   = addr_q;
   assign bdev_req_bits_offset = offset_q;
   assign bdev_req_bits_len    = len_q;
   assign bdev_req_bits_tag    = tag_q;
   assign bdev_data_bits_tag   = tag_q;

endmodule
